// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and constants for the two-port CPU memory arbiter.
package cpu_mem_arb_pkg;

  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned PORT_FETCH = 0;
  localparam int unsigned PORT_DATA  = 1;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_WAIT
  } arb_state_e;

  // One-hot pulse vector for a single port index.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_select2.sv
// Combinational grant picker for two requesters.
// With both requesting, fixed priority favours the data port; round-robin
// mode hands the grant to the port that did not win last time.
module arb_select2
  import cpu_mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 last_grant_i,
  input  logic                 round_robin_i,
  output logic                 sel_o
);

  // Pick a port from the current request vector.
  always_comb begin
    sel_o = 1'(PORT_FETCH);
    case (req_i)
      2'b01:   sel_o = 1'(PORT_FETCH);
      2'b10:   sel_o = 1'(PORT_DATA);
      2'b11:   sel_o = round_robin_i ? ~last_grant_i : 1'(PORT_DATA);
      default: sel_o = 1'(PORT_FETCH);
    endcase
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch (port 0) and data (port 1).
// One transaction in flight: accept on i_mem_ready in IDLE, complete on the
// next i_mem_ready in WAIT, and route the response back to the owning port.
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_PORTS-1:0]              i_req_valid,
  input  logic [NUM_PORTS-1:0]              i_req_write_en,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  i_req_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  i_req_data,
  output logic [NUM_PORTS-1:0]              o_req_ready,
  output logic [NUM_PORTS-1:0]              o_rsp_valid,
  output logic [DATA_W-1:0]                 o_rsp_data,
  input  logic                              i_mem_ready,
  output logic                              o_mem_req_valid,
  output logic                              o_mem_write_en,
  output logic [ADDR_W-1:0]                 o_mem_addr,
  output logic [DATA_W-1:0]                 o_mem_data,
  input  logic [DATA_W-1:0]                 i_mem_data
);

  localparam logic RrEn = (ROUND_ROBIN != 0);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_data_q, lat_data_d;

  logic                 sel;
  logic [NUM_PORTS-1:0] req_ready_c;
  logic [NUM_PORTS-1:0] rsp_valid_c;
  logic [DATA_W-1:0]    rsp_data_c;
  logic                 mem_valid_c;
  logic                 mem_we_c;

  arb_select2 u_select (
    .req_i         (i_req_valid),
    .last_grant_i  (last_grant_q),
    .round_robin_i (RrEn),
    .sel_o         (sel)
  );

  // FSM next state, request latching and bus muxing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_data_d   = lat_data_q;
    req_ready_c  = '0;
    rsp_valid_c  = '0;
    rsp_data_c   = '0;
    mem_valid_c  = 1'b0;
    mem_we_c     = 1'b0;
    o_mem_addr   = lat_addr_q;
    o_mem_data   = lat_data_q;

    case (state_q)
      ARB_IDLE: begin
        // Bus follows the current selection; it may change until acceptance.
        mem_valid_c = |i_req_valid;
        mem_we_c    = i_req_valid[sel] & i_req_write_en[sel];
        o_mem_addr  = i_req_addr[sel];
        o_mem_data  = i_req_data[sel];
        if (mem_valid_c && i_mem_ready) begin
          req_ready_c  = port_onehot(sel);
          owner_d      = sel;
          last_grant_d = sel;
          lat_we_d     = i_req_write_en[sel];
          lat_addr_d   = i_req_addr[sel];
          lat_data_d   = i_req_data[sel];
          state_d      = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        mem_we_c = lat_we_q;
        if (i_mem_ready) begin
          rsp_valid_c = port_onehot(owner_q);
          rsp_data_c  = lat_we_q ? '0 : i_mem_data;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Control outputs are forced quiet while reset is asserted, even between edges.
  always_comb begin
    o_req_ready     = i_rst ? '0   : req_ready_c;
    o_rsp_valid     = i_rst ? '0   : rsp_valid_c;
    o_rsp_data      = i_rst ? '0   : rsp_data_c;
    o_mem_req_valid = i_rst ? 1'b0 : mem_valid_c;
    o_mem_write_en  = i_rst ? 1'b0 : mem_we_c;
  end

  // State and latched request registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_data_q   <= lat_data_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: a fixed-priority and a round-robin instance share
// one stimulus stream. The fixed-priority instance is checked against a vector
// table and hand sequences; the round-robin instance against a scoreboard model.
module tb_cpu_mem_arbiter;

  localparam logic [31:0] P0D = 32'h0BAD_F00D;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_data;
  logic             mem_ready;
  logic [31:0]      mem_data;

  logic [1:0]  fp_req_ready, fp_rsp_valid, rr_req_ready, rr_rsp_valid;
  logic [31:0] fp_rsp_data, fp_mem_addr, fp_mem_data;
  logic [31:0] rr_rsp_data, rr_mem_addr, rr_mem_data;
  logic        fp_mem_valid, fp_mem_we, rr_mem_valid, rr_mem_we;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0)) dut_fp (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_write_en(req_we),
    .i_req_addr(req_addr), .i_req_data(req_data), .o_req_ready(fp_req_ready),
    .o_rsp_valid(fp_rsp_valid), .o_rsp_data(fp_rsp_data), .i_mem_ready(mem_ready),
    .o_mem_req_valid(fp_mem_valid), .o_mem_write_en(fp_mem_we), .o_mem_addr(fp_mem_addr),
    .o_mem_data(fp_mem_data), .i_mem_data(mem_data)
  );

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1)) dut_rr (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_write_en(req_we),
    .i_req_addr(req_addr), .i_req_data(req_data), .o_req_ready(rr_req_ready),
    .o_rsp_valid(rr_rsp_valid), .o_rsp_data(rr_rsp_data), .i_mem_ready(mem_ready),
    .o_mem_req_valid(rr_mem_valid), .o_mem_write_en(rr_mem_we), .o_mem_addr(rr_mem_addr),
    .o_mem_data(rr_mem_data), .i_mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  rr;
    logic [1:0]  rv;
    logic [31:0] rd;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] acc_fp[$];
  logic [1:0] acc_rr[$];

  // Reference model state for the round-robin instance.
  logic m_wait, m_last, m_owner, m_we;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  we;
    logic [31:0] a0;
    logic        rdy;
    logic [31:0] md;
    logic [1:0]  x_rr;
    logic [1:0]  x_rv;
    logic [31:0] x_rd;
    logic        x_mv;
    logic        x_mwe;
    logic        chk_bus;
    logic [31:0] x_ma;
    logic [31:0] x_md;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wait  = 1'b0;
    m_last  = 1'b0;
    m_owner = 1'b0;
    m_we    = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] v, input logic [1:0] we, input logic rdy,
                            input logic [31:0] md);
    exp_t e;
    logic sel;
    e = '0;
    if (!m_wait) begin
      if (v != 2'b00 && rdy) begin
        sel     = (v == 2'b11) ? ~m_last : v[1];
        e.rr    = sel ? 2'b10 : 2'b01;
        m_owner = sel;
        m_last  = sel;
        m_we    = we[sel];
        m_wait  = 1'b1;
      end
    end else if (rdy) begin
      e.rv   = m_owner ? 2'b10 : 2'b01;
      e.rd   = m_we ? 32'h0 : md;
      m_wait = 1'b0;
    end
    sb_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard underflow: actual=empty required=entry");
    end else begin
      e = sb_q.pop_front();
      chk("rr req_ready", 32'(rr_req_ready), 32'(e.rr));
      chk("rr rsp_valid", 32'(rr_rsp_valid), 32'(e.rv));
      chk("rr rsp_data", rr_rsp_data, e.rd);
    end
    if (fp_req_ready != 2'b00) acc_fp.push_back(fp_req_ready);
    if (rr_req_ready != 2'b00) acc_rr.push_back(rr_req_ready);
  endtask

  // Called just after a rising edge: apply inputs, then sample mid-cycle.
  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic rdy,
                       input logic [31:0] md);
    req_valid = v;
    req_we    = we;
    mem_ready = rdy;
    mem_data  = md;
    model_step(v, we, rdy, md);
    #2;
    sample();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " fp req_ready"}, 32'(fp_req_ready), 32'h0);
    chk({tag, " fp rsp_valid"}, 32'(fp_rsp_valid), 32'h0);
    chk({tag, " fp rsp_data"}, fp_rsp_data, 32'h0);
    chk({tag, " fp mem_valid"}, 32'(fp_mem_valid), 32'h0);
    chk({tag, " fp mem_we"}, 32'(fp_mem_we), 32'h0);
    chk({tag, " rr req_ready"}, 32'(rr_req_ready), 32'h0);
    chk({tag, " rr rsp_valid"}, 32'(rr_rsp_valid), 32'h0);
    chk({tag, " rr mem_valid"}, 32'(rr_mem_valid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ord [4];
    ord = '{2'b10, 2'b01, 2'b10, 2'b01};

    vecs[0]  = '{2'b00, 2'b00, 32'h100, 1'b1, 32'h0, 2'b00, 2'b00, 32'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{2'b01, 2'b00, 32'h100, 1'b1, 32'h0, 2'b01, 2'b00, 32'h0,
                 1'b1, 1'b0, 1'b1, 32'h100, P0D};
    vecs[2]  = '{2'b00, 2'b00, 32'h100, 1'b1, 32'hDEADBEEF, 2'b00, 2'b01, 32'hDEADBEEF,
                 1'b0, 1'b0, 1'b1, 32'h100, P0D};
    vecs[3]  = '{2'b11, 2'b10, 32'h10, 1'b1, 32'h0, 2'b10, 2'b00, 32'h0,
                 1'b1, 1'b1, 1'b1, 32'h20, 32'h55};
    vecs[4]  = '{2'b11, 2'b10, 32'h10, 1'b1, 32'h1234, 2'b00, 2'b10, 32'h0,
                 1'b0, 1'b1, 1'b1, 32'h20, 32'h55};
    vecs[5]  = '{2'b11, 2'b10, 32'h10, 1'b1, 32'h0, 2'b10, 2'b00, 32'h0,
                 1'b1, 1'b1, 1'b1, 32'h20, 32'h55};
    vecs[6]  = '{2'b11, 2'b10, 32'h10, 1'b0, 32'h0, 2'b00, 2'b00, 32'h0,
                 1'b0, 1'b1, 1'b1, 32'h20, 32'h55};
    vecs[7]  = '{2'b11, 2'b10, 32'h10, 1'b1, 32'h9999, 2'b00, 2'b10, 32'h0,
                 1'b0, 1'b1, 1'b1, 32'h20, 32'h55};
    vecs[8]  = '{2'b11, 2'b10, 32'h10, 1'b0, 32'h0, 2'b00, 2'b00, 32'h0,
                 1'b1, 1'b1, 1'b1, 32'h20, 32'h55};
    vecs[9]  = '{2'b01, 2'b10, 32'h10, 1'b0, 32'h0, 2'b00, 2'b00, 32'h0,
                 1'b1, 1'b0, 1'b1, 32'h10, P0D};
    vecs[10] = '{2'b01, 2'b10, 32'h10, 1'b1, 32'h0, 2'b01, 2'b00, 32'h0,
                 1'b1, 1'b0, 1'b1, 32'h10, P0D};
    vecs[11] = '{2'b00, 2'b10, 32'h10, 1'b1, 32'h13572468, 2'b00, 2'b01, 32'h13572468,
                 1'b0, 1'b0, 1'b1, 32'h10, P0D};

    rst         = 1'b0;
    req_valid   = 2'b11;
    req_we      = 2'b11;
    req_addr[0] = 32'h100;
    req_addr[1] = 32'h20;
    req_data[0] = P0D;
    req_data[1] = 32'h55;
    mem_ready   = 1'b1;
    mem_data    = 32'h0;
    model_reset();

    // Reset state: control outputs quiet even with every input asserted.
    #1 rst = 1'b1;
    #1 chk_quiet("reset");
    tick();
    rst = 1'b0;
    model_reset();

    // Vector table against the fixed-priority instance.
    for (int i = 0; i < 12; i++) begin
      req_addr[0] = vecs[i].a0;
      drive(vecs[i].v, vecs[i].we, vecs[i].rdy, vecs[i].md);
      chk($sformatf("row%0d req_ready", i), 32'(fp_req_ready), 32'(vecs[i].x_rr));
      chk($sformatf("row%0d rsp_valid", i), 32'(fp_rsp_valid), 32'(vecs[i].x_rv));
      chk($sformatf("row%0d rsp_data", i), fp_rsp_data, vecs[i].x_rd);
      chk($sformatf("row%0d mem_valid", i), 32'(fp_mem_valid), 32'(vecs[i].x_mv));
      chk($sformatf("row%0d mem_we", i), 32'(fp_mem_we), 32'(vecs[i].x_mwe));
      if (vecs[i].chk_bus) begin
        chk($sformatf("row%0d mem_addr", i), fp_mem_addr, vecs[i].x_ma);
        chk($sformatf("row%0d mem_data", i), fp_mem_data, vecs[i].x_md);
      end
      tick();
    end

    // Continuous conflict: fixed priority starves fetch, round-robin alternates.
    reset_all();
    acc_fp.delete();
    acc_rr.delete();
    req_addr[0] = 32'h10;
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 2'b10, 1'b1, 32'hA000_0000 + 32'(i));
      if (fp_rsp_valid != 2'b00) chk("fp conflict rsp_data", fp_rsp_data, 32'h0);
      tick();
    end
    chk("fp conflict grants", 32'(acc_fp.size()), 32'd4);
    foreach (acc_fp[k]) chk($sformatf("fp grant%0d", k), 32'(acc_fp[k]), 32'(2'b10));
    chk("rr conflict grants", 32'(acc_rr.size()), 32'd4);
    foreach (acc_rr[k]) if (k < 4) chk($sformatf("rr grant%0d", k), 32'(acc_rr[k]),
                                       32'(ord[k]));

    // Slow memory: five stalled cycles in WAIT before completion.
    req_addr[0] = 32'h300;
    drive(2'b01, 2'b00, 1'b1, 32'h0);
    chk("slow accept", 32'(fp_req_ready), 32'(2'b01));
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF);
      chk($sformatf("slow%0d mem_valid", i), 32'(fp_mem_valid), 32'h0);
      chk($sformatf("slow%0d mem_addr", i), fp_mem_addr, 32'h300);
      chk($sformatf("slow%0d pulses", i), 32'({fp_req_ready, fp_rsp_valid}), 32'h0);
      tick();
    end
    drive(2'b00, 2'b00, 1'b1, 32'hCAFE_F00D);
    chk("slow rsp_valid", 32'(fp_rsp_valid), 32'(2'b01));
    chk("slow rsp_data", fp_rsp_data, 32'hCAFE_F00D);
    tick();

    // Asynchronous reset between edges while a write is in flight.
    req_addr[1] = 32'h40;
    req_data[1] = 32'h77;
    drive(2'b10, 2'b10, 1'b1, 32'h0);
    chk("areset accept", 32'(fp_req_ready), 32'(2'b10));
    tick();
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    #1;
    rst       = 1'b1;
    req_valid = 2'b11;
    mem_ready = 1'b1;
    mem_data  = 32'h1111;
    #1 chk_quiet("areset mid");
    tick();
    chk_quiet("areset edge");
    rst = 1'b0;
    model_reset();
    req_addr[0] = 32'h500;
    drive(2'b01, 2'b00, 1'b1, 32'h0);
    chk("post-reset accept", 32'(fp_req_ready), 32'(2'b01));
    chk("post-reset addr", fp_mem_addr, 32'h500);
    tick();
    drive(2'b00, 2'b00, 1'b1, 32'h600D);
    chk("post-reset rsp_valid", 32'(fp_rsp_valid), 32'(2'b01));
    chk("post-reset rsp_data", fp_rsp_data, 32'h600D);
    tick();

    // Idle with no requests, memory ready, stale write flags on the inputs.
    for (int i = 0; i < 10; i++) begin
      drive(2'b00, 2'b11, 1'b1, 32'h0);
      chk($sformatf("idle%0d fp mem_valid", i), 32'(fp_mem_valid), 32'h0);
      chk($sformatf("idle%0d fp mem_we", i), 32'(fp_mem_we), 32'h0);
      chk($sformatf("idle%0d rr mem_we", i), 32'(rr_mem_we), 32'h0);
      chk($sformatf("idle%0d fp req_ready", i), 32'(fp_req_ready), 32'h0);
      tick();
    end
    drive(2'b10, 2'b10, 1'b1, 32'h0);
    chk("idle exit accept", 32'(fp_req_ready), 32'(2'b10));
    tick();
    drive(2'b00, 2'b00, 1'b1, 32'h0);
    chk("idle exit rsp", 32'(fp_rsp_valid), 32'(2'b10));
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares the single CPU memory port between two requesters: port 0 = instruction fetch, port 1 = data load/store.
- Serialises one outstanding transaction at a time using a two-phase memory handshake (request accepted on i_mem_ready, response returned on the next i_mem_ready).
- Returns read data or write completion to the owning port only.
- Sits between the fetch/LSU front-ends and the memory system.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ROUND_ROBIN, 0, 0 = fixed priority (data port wins); 1 = alternate grants when both ports request.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset. Asynchronous, active-high.
- i_req_valid  in  2  per-port request pending. Bit 0 = fetch, bit 1 = data.
- i_req_write_en  in  2  per-port store flag.
- i_req_addr  in  2xADDR_W  per-port address.
- i_req_data  in  2xDATA_W  per-port store data.
- o_req_ready  out  2  one-hot pulse: the port's request was accepted this cycle.
- o_rsp_valid  out  2  one-hot pulse: the port's transaction completed this cycle.
- o_rsp_data  out  DATA_W  load data. 0 for writes and when no response.
- i_mem_ready  in  1  memory ready / transaction complete.
- o_mem_req_valid  out  1  request presented to memory.
- o_mem_write_en  out  1  store flag to memory.
- o_mem_addr  out  ADDR_W  address to memory.
- o_mem_data  out  DATA_W  store data to memory.
- i_mem_data  in  DATA_W  read data from memory.

Behaviour:
- Clock/reset: one clock, i_clk. i_rst is asynchronous and active-high. All flops clear on posedge i_rst.
- Outputs under reset: while i_rst is high, o_req_ready = 0, o_rsp_valid = 0, o_mem_req_valid = 0, o_mem_write_en = 0, o_rsp_data = 0.
- Reset values of state: state = IDLE, owner = 0, last_grant = 0 (fetch), latched request fields = 0.
- States: IDLE, WAIT.
- IDLE, grant selection:
  - One port requesting: that port is selected.
  - Both requesting, ROUND_ROBIN = 0: port 1 is selected.
  - Both requesting, ROUND_ROBIN = 1: the port other than last_grant is selected.
- IDLE, bus drive: the memory bus is driven combinationally from the selected port. o_mem_req_valid = |i_req_valid.
- IDLE, acceptance: if a request is selected and i_mem_ready = 1:
  - o_req_ready[sel] = 1 in the same cycle.
  - Latch sel, write_en, addr, data.
  - last_grant <= sel.
  - Go to WAIT.
- IDLE, no acceptance: with no request or i_mem_ready = 0, o_req_ready = 0, the bus is still driven from the selection, and state stays IDLE.
- Requester rule: a requester holds valid/write_en/addr/data stable until it sees o_req_ready. The arbiter may switch selection between cycles until acceptance; this is legal because acceptance is atomic.
- WAIT, bus drive:
  - o_mem_req_valid = 0.
  - o_mem_addr, o_mem_data, o_mem_write_en hold the latched values.
  - o_req_ready = 0. New requests stall.
- WAIT, completion: when i_mem_ready = 1:
  - o_rsp_valid[owner] = 1.
  - o_rsp_data = i_mem_data for reads, 0 for writes.
  - Go to IDLE.
- WAIT, hold: with i_mem_ready = 0, state stays WAIT indefinitely. There is no timeout.
- Latency: acceptance to response is at least 1 cycle. A new request is accepted no earlier than the cycle after a response, so peak throughput is one transaction per 2 cycles.
- Simultaneous events:
  - A response and a new request in the same cycle: the new request waits until IDLE.
  - A port's i_req_valid during its own WAIT is ignored.
- Reset mid-transaction: the in-flight response is dropped and no rsp pulse is produced. The memory model must also reset.
- Invariants:
  - o_req_ready and o_rsp_valid are never both nonzero in the same cycle.
  - Each is one-hot or zero.

Decomposition:
- Package cpu_mem_arb_pkg holds:
  - state enum {ARB_IDLE, ARB_WAIT};
  - localparams PORT_FETCH = 0 and PORT_DATA = 1;
  - NUM_PORTS = 2.
- Sub-module arb_select2: a purely combinational grant picker with inputs req[1:0], last_grant, round_robin, and output sel. The top module holds the FSM, latches and bus muxing.

Test Plan:
- Fetch-only read: port 0 requests addr 0x100 with memory always ready and i_mem_data = 0xDEADBEEF at completion -> o_req_ready = 01 in cycle 0, o_rsp_valid = 01 with data 0xDEADBEEF in cycle 1, port 1 sees nothing.
- Conflict, ROUND_ROBIN = 0: both request continuously (port 0 read 0x10, port 1 write 0x20 with data 0x55) -> port 1 is granted on every acceptance and port 0 starves. Port 1's response has o_rsp_data = 0.
- Conflict, ROUND_ROBIN = 1: both request continuously -> acceptance order is 1, 0, 1, 0, and each response is routed to the correct port.
- Slow memory: i_mem_ready low for 5 cycles in WAIT -> bus holds the latched addr, o_mem_req_valid = 0, no pulses; the response arrives on the first ready cycle.
- Async reset during WAIT, asserted between clock edges -> outputs drop immediately, no o_rsp_valid pulse, IDLE after deassert, and the next request is accepted normally.
- Idle with no requests: i_mem_ready = 1 and i_req_valid = 00 for 10 cycles -> o_mem_req_valid = 0, o_mem_write_en = 0, state stays IDLE.
